// File: rtl/seg_serial_tx.sv
// Encodes eight hex digits into active-low 7-segment bytes and shifts the 64-bit
// frame MSB first into a cascaded 74HC595-style chain, then pulses the latch.
module seg_serial_tx #(
  parameter int unsigned DIV       = 2,
  parameter int unsigned BLINK_BIT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  le_in,
  output logic        seg_clk,
  output logic        seg_dat,
  output logic        seg_clr,
  output logic        seg_load,
  output logic        busy,
  output logic        done
);

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned BLINK_W = BLINK_BIT + 1;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               seg_clk_q, seg_clk_d;
  logic               seg_dat_q, seg_dat_d;
  logic               seg_clr_q, seg_clr_d;
  logic               seg_load_q, seg_load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame_enc;

  // Segment pattern g..a, active-low, decimal point excluded.
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Frame as it would be captured this cycle; a blinking digit in its off phase is fully blank.
  always_comb begin
    frame_enc = '0;
    for (int i = 0; i < 8; i++) begin
      if (le_in[i] && blink_q[BLINK_BIT]) begin
        frame_enc[8*i +: 8] = 8'hFF;
      end else begin
        frame_enc[8*i +: 8] = {~point_in[i], hex_seg(disp_num[4*i +: 4])};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    blink_d = blink_q + BLINK_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT_LO;
          shift_d = frame_enc;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          bit_d   = bit_q + CNT_W'(1);
          state_d = (bit_q == BIT_LAST) ? LOAD : SHIFT_LO;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LOAD: begin
        if (div_q == DIV_LAST) begin
          state_d = DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they line up with the state register.
    seg_clk_d  = (state_d == SHIFT_HI);
    seg_dat_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shift_d[FRAME_W-1] : 1'b0;
    seg_load_d = (state_d == LOAD);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    seg_clr_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      blink_q    <= '0;
      seg_clk_q  <= 1'b0;
      seg_dat_q  <= 1'b0;
      seg_clr_q  <= 1'b0;
      seg_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      blink_q    <= blink_d;
      seg_clk_q  <= seg_clk_d;
      seg_dat_q  <= seg_dat_d;
      seg_clr_q  <= seg_clr_d;
      seg_load_q <= seg_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_dat  = seg_dat_q;
  assign seg_clr  = seg_clr_q;
  assign seg_load = seg_load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seg_serial_tx.sv
// Bench for seg_serial_tx: directed and random frames compared against a digit-table
// model, plus handshake, blink and mid-frame reset scenarios.
module tb_seg_serial_tx;

  localparam int unsigned DIV       = 2;
  localparam int unsigned BLINK_BIT = 3;
  localparam int          FRAME_CYC = 1 + 129 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] disp_num = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  le_in = '0;
  logic        seg_clk, seg_dat, seg_clr, seg_load, busy, done;

  int          ncmp = 0;
  int          nfail = 0;
  int unsigned edge_cnt;
  logic [63:0] got_frame;
  logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_serial_tx #(.DIV(DIV), .BLINK_BIT(BLINK_BIT)) dut (
    .clk(clk), .rst(rst), .start(start), .disp_num(disp_num), .point_in(point_in),
    .le_in(le_in), .seg_clk(seg_clk), .seg_dat(seg_dat), .seg_clr(seg_clr),
    .seg_load(seg_load), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; its low bits equal the free-running blink counter.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] le, input bit phase);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      if (le[i] && phase) b = 8'hFF;
      else begin
        b = hex_tbl[d[4*i +: 4]];
        if (p[i]) b = b & 8'h7F;
      end
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] le,
                           input bit hold, input int repulse_at, input string tag);
    logic [63:0] exp;
    bit          phase;
    int          nbits, clk_hi, loads, dones, viol, clr_low;
    logic        prev_clk, prev_dat;
    disp_num = d; point_in = p; le_in = le; start = 1'b1;
    phase = edge_cnt[BLINK_BIT];
    exp = model_frame(d, p, le, phase);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    got_frame = '0;
    nbits = 0; clk_hi = 0; loads = 0; dones = 0; viol = 0; clr_low = 0;
    prev_clk = 1'b0; prev_dat = 1'b0;
    for (int c = 1; c <= FRAME_CYC + 1; c++) begin
      @(negedge clk);
      if (c == 3) begin
        disp_num = $urandom; point_in = 8'($urandom); le_in = 8'($urandom);
      end
      if (c == repulse_at) start = 1'b1;
      else if (c == repulse_at + 1 && !hold) start = 1'b0;
      if (c == 1) begin
        check($sformatf("%s.busy_first", tag), 64'(busy), 64'(1'b1));
        check($sformatf("%s.dat_first", tag), 64'(seg_dat), 64'(exp[63]));
      end
      if (seg_clk && !prev_clk) begin
        got_frame = {got_frame[62:0], seg_dat};
        nbits++;
      end
      if (seg_clk && prev_clk && seg_dat !== prev_dat) viol++;
      clk_hi += int'(seg_clk);
      loads  += int'(seg_load);
      dones  += int'(done);
      if (!seg_clr) clr_low++;
      if (c == FRAME_CYC - 1) check($sformatf("%s.load_last", tag), 64'(seg_load), 64'(1'b1));
      if (c == FRAME_CYC) begin
        check($sformatf("%s.done_at", tag), 64'(done), 64'(1'b1));
        check($sformatf("%s.busy_at_done", tag), 64'(busy), 64'(1'b1));
      end
      if (c == FRAME_CYC + 1) begin
        check($sformatf("%s.busy_after", tag), 64'(busy), 64'(1'b0));
        check($sformatf("%s.done_after", tag), 64'(done), 64'(1'b0));
      end
      prev_clk = seg_clk;
      prev_dat = seg_dat;
    end
    check($sformatf("%s.nbits", tag), 64'(nbits), 64'(64));
    check($sformatf("%s.frame", tag), got_frame, exp);
    check($sformatf("%s.clk_hi", tag), 64'(clk_hi), 64'(64 * DIV));
    check($sformatf("%s.loads", tag), 64'(loads), 64'(DIV));
    check($sformatf("%s.dones", tag), 64'(dones), 64'(1));
    check($sformatf("%s.dat_stable", tag), 64'(viol), 64'(0));
    check($sformatf("%s.clr_high", tag), 64'(clr_low), 64'(0));
  endtask

  task automatic wait_phase(input bit want);
    for (int k = 0; k < 64 && edge_cnt[BLINK_BIT] != want; k++) @(negedge clk);
    check("blink.phase_reached", 64'(edge_cnt[BLINK_BIT]), 64'(want));
  endtask

  initial begin
    // Reset with live inputs: every output stays low.
    rst = 1'b0; start = 1'b1;
    disp_num = $urandom; point_in = 8'($urandom); le_in = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset.outputs", 64'({seg_clk, seg_dat, seg_clr, seg_load, busy, done}), 64'(0));
    end
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("reset.clr_before_edge", 64'(seg_clr), 64'(1'b0));
    @(negedge clk);
    check("reset.clr_after_edge", 64'(seg_clr), 64'(1'b1));
    check("reset.busy_idle", 64'(busy), 64'(1'b0));

    run_frame(32'h01234567, 8'h00, 8'h00, 1'b0, 0, "hex");
    check("hex.literal", got_frame, 64'hC0F9A4B0999282F8);

    run_frame(32'h89ABCDEF, 8'h81, 8'h00, 1'b0, 0, "dp");
    check("dp.literal", got_frame, 64'h00908883C6A1860E);

    wait_phase(1'b1);
    run_frame(32'h00000000, 8'h00, 8'h80, 1'b0, 0, "blink_on");
    check("blink_on.literal", got_frame, 64'hFFC0C0C0C0C0C0C0);
    wait_phase(1'b0);
    run_frame(32'h00000000, 8'h00, 8'h80, 1'b0, 0, "blink_off");
    check("blink_off.literal", got_frame, 64'hC0C0C0C0C0C0C0C0);

    // Start re-pulsed mid-frame must be ignored.
    run_frame($urandom, 8'($urandom), 8'h00, 1'b0, 50, "repulse");

    // Start held high: frames back to back with one idle cycle between.
    run_frame($urandom, 8'($urandom), 8'($urandom), 1'b1, 0, "held0");
    run_frame($urandom, 8'($urandom), 8'($urandom), 1'b1, 0, "held1");
    run_frame($urandom, 8'($urandom), 8'($urandom), 1'b0, 0, "held2");

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      run_frame($urandom, 8'($urandom), 8'($urandom), 1'b0, 0, $sformatf("rand%0d", n));
    end

    // Reset in the middle of a frame aborts without latching.
    disp_num = 32'h88888888; point_in = 8'h00; le_in = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("abort.busy_before", 64'(busy), 64'(1'b1));
    rst = 1'b0;
    #1;
    check("abort.outputs", 64'({seg_clk, seg_dat, seg_clr, seg_load, busy, done}), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.no_latch", 64'({seg_load, done}), 64'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort.clr_back", 64'(seg_clr), 64'(1'b1));
    run_frame($urandom, 8'($urandom), 8'($urandom), 1'b0, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
